// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver (start, DATA_BITS data LSB first,
// optional even parity, stop). Reports each frame with a one-cycle done pulse.
// Ports: i_clock, i_reset (async, active-high), i_tick (16x baud strobe),
//   i_rx (async serial line, idle high), o_data, o_rx_done, o_frame_err,
//   o_parity_err.
// Config: define UART_RX_PARITY_EN to add the parity bit after the data bits.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_TICKS = 16
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_tick,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_rx_done,
    output logic                 o_frame_err,
    output logic                 o_parity_err
);

    localparam int NW = $clog2(DATA_BITS) + 1;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t               state_q, state_d;
    logic                 rx_meta_q, rx_s_q;
    logic [3:0]           s_cnt_q, s_cnt_d;
    logic [NW-1:0]        n_cnt_q, n_cnt_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 done_q, done_d;
    logic                 ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_q, par_d;
    logic                 perr_q, perr_d;
`endif

    // Two-flop synchronizer; resets to the idle line level.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= i_rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            s_cnt_q <= '0;
            n_cnt_q <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_cnt_q <= s_cnt_d;
            n_cnt_q <= n_cnt_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        s_cnt_d = s_cnt_q;
        n_cnt_d = n_cnt_q;
        sh_d    = sh_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = perr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    s_cnt_d = '0;
                end
            end
            START: begin
                if (i_tick) begin
                    if (s_cnt_q == 4'd7) begin
                        // Line must still be low mid start bit.
                        if (!rx_s_q) begin
                            state_d = DATA;
                            s_cnt_d = '0;
                            n_cnt_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (i_tick) begin
                    if (s_cnt_q == 4'd15) begin
                        sh_d    = {rx_s_q, sh_q[DATA_BITS-1:1]};
                        s_cnt_d = '0;
                        n_cnt_d = n_cnt_q + NW'(1);
                        if (n_cnt_q == NW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (i_tick) begin
                    if (s_cnt_q == 4'd15) begin
                        par_d   = rx_s_q;
                        s_cnt_d = '0;
                        state_d = STOP;
                    end else begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end
                end
            end
`endif
            STOP: begin
                if (i_tick) begin
                    if (s_cnt_q == 4'(STOP_TICKS - 1)) begin
                        state_d = IDLE;
                        data_d  = sh_q;
                        ferr_d  = ~rx_s_q;
                        done_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_d  = (^sh_q) ^ par_q;
`endif
                    end else begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_data      = data_q;
    assign o_rx_done   = done_q;
    assign o_frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = perr_q;
`else
    assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx with a frame-level model.
// Ticks every 4 clocks, 64 clocks per bit.
module tb_uart_rx;

    localparam int DW  = 8;
    localparam int BIT = 64;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic          clk  = 1'b0;
    logic          rst  = 1'b1;
    logic          tick = 1'b0;
    logic          rx   = 1'b1;
    logic [DW-1:0] o_data;
    logic          done, ferr, perr;

    int tests  = 0;
    int failed = 0;

    uart_rx #(.DATA_BITS(DW), .STOP_TICKS(16)) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_tick       (tick),
        .i_rx         (rx),
        .o_data       (o_data),
        .o_rx_done    (done),
        .o_frame_err  (ferr),
        .o_parity_err (perr)
    );

    always #5 clk = ~clk;

    int tcnt = 0;
    always @(posedge clk) begin
        tcnt <= (tcnt == 3) ? 0 : tcnt + 1;
        tick <= (tcnt == 3);
    end

    // Frame monitor: records {data, frame_err, parity_err} per done pulse.
    logic [DW+1:0] got_q[$];
    int   pulses    = 0;
    int   wide      = 0;
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        if (done === 1'b1) begin
            got_q.push_back({o_data, ferr, perr});
            pulses++;
            if (done_prev) wide++;
        end
        done_prev = (done === 1'b1);
    end

    // Expected report of one frame, straight from the frame format.
    function automatic logic [DW+1:0] model(logic [DW-1:0] d, logic stop_b,
                                             logic pbit);
        logic pe;
        pe = PAR ? ((^d) ^ pbit) : 1'b0;
        return {d, ~stop_b, pe};
    endfunction

    task automatic idle(int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // A low stop bit is held 40 clocks then released, so the line is high
    // again well before any spurious start could be sampled mid-bit.
    task automatic send_frame(logic [DW-1:0] d, logic stop_b, logic pbit);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < DW; i++) begin
            rx = d[i];
            repeat (BIT) @(negedge clk);
        end
        if (PAR) begin
            rx = pbit;
            repeat (BIT) @(negedge clk);
        end
        if (stop_b) begin
            rx = 1'b1;
            repeat (BIT) @(negedge clk);
        end else begin
            rx = 1'b0;
            repeat (40) @(negedge clk);
            rx = 1'b1;
            repeat (BIT - 40) @(negedge clk);
        end
    endtask

    task automatic wait_got(int n, string name);
        for (int i = 0; i < 400 && got_q.size() < n; i++) @(negedge clk);
        if (got_q.size() < n) begin
            tests++;
            failed++;
            $display("FAIL %s timeout: got %0d frames, need %0d",
                     name, got_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        idle(200);
        tests++;
        if (pulses !== 0) begin
            failed++;
            $display("FAIL reset_done: pulses=%0d need 0", pulses);
        end
        tests++;
        if (o_data !== '0) begin
            failed++;
            $display("FAIL reset_data: got %h need 00", o_data);
        end
        tests++;
        if (ferr !== 1'b0 || perr !== 1'b0) begin
            failed++;
            $display("FAIL reset_err: ferr=%b perr=%b need 0 0", ferr, perr);
        end
        tests++;
        if (done !== 1'b0) begin
            failed++;
            $display("FAIL reset_pulse: done=%b need 0", done);
        end
    endtask

    task automatic test_frame();
        logic [DW+1:0] exp, got;
        exp = model(8'hA3, 1'b1, 1'b0);
        send_frame(8'hA3, 1'b1, 1'b0);
        wait_got(1, "frame_a3");
        if (got_q.size() > 0) begin
            got = got_q.pop_front();
            tests++;
            if (got !== exp) begin
                failed++;
                $display("FAIL frame_a3: got %h need %h", got, exp);
            end
        end
        idle(BIT);
        tests++;
        if (pulses !== 1 || wide !== 0 || got_q.size() != 0) begin
            failed++;
            $display("FAIL frame_a3_pulse: pulses=%0d wide=%0d need 1 0",
                     pulses, wide);
        end
    endtask

    task automatic test_glitch();
        int p0;
        p0 = pulses;
        rx = 1'b0;
        repeat (12) @(negedge clk);
        idle(200);
        tests++;
        if (pulses !== p0) begin
            failed++;
            $display("FAIL glitch_done: pulses=%0d need %0d", pulses, p0);
        end
        tests++;
        if (o_data !== 8'hA3) begin
            failed++;
            $display("FAIL glitch_hold: got %h need a3", o_data);
        end
    endtask

    task automatic test_frame_err();
        logic [DW+1:0] exp, got;
        exp = model(8'h55, 1'b0, 1'b0);
        send_frame(8'h55, 1'b0, 1'b0);
        wait_got(1, "frame_err");
        if (got_q.size() > 0) begin
            got = got_q.pop_front();
            tests++;
            if (got !== exp) begin
                failed++;
                $display("FAIL frame_err: got %h need %h", got, exp);
            end
            tests++;
            if (got[1] !== 1'b1) begin
                failed++;
                $display("FAIL frame_err_flag: got %b need 1", got[1]);
            end
        end
        idle(2 * BIT);
        tests++;
        if (got_q.size() != 0) begin
            failed++;
            $display("FAIL frame_err_extra: got %0d extra frames need 0",
                     got_q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [DW+1:0] exp, got;
        int p0;
        p0 = pulses;
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
        repeat (4 * BIT + 32) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (o_data !== '0 || ferr !== 1'b0) begin
            failed++;
            $display("FAIL reset_mid_clr: data=%h ferr=%b need 00 0",
                     o_data, ferr);
        end
        rst = 1'b0;
        idle(300);
        tests++;
        if (pulses !== p0) begin
            failed++;
            $display("FAIL reset_mid_done: pulses=%0d need %0d", pulses, p0);
        end
        exp = model(8'h3C, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0);
        wait_got(1, "reset_mid_3c");
        if (got_q.size() > 0) begin
            got = got_q.pop_front();
            tests++;
            if (got !== exp) begin
                failed++;
                $display("FAIL reset_mid_3c: got %h need %h", got, exp);
            end
        end
        idle(BIT);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        logic [DW+1:0] got;
        send_frame(8'h01, 1'b1, 1'b0);
        send_frame(8'h01, 1'b1, 1'b1);
        wait_got(2, "parity");
        if (got_q.size() >= 2) begin
            got = got_q.pop_front();
            tests++;
            if (got !== {8'h01, 1'b0, 1'b1}) begin
                failed++;
                $display("FAIL parity_bad: got %h need %h", got,
                         {8'h01, 1'b0, 1'b1});
            end
            got = got_q.pop_front();
            tests++;
            if (got !== {8'h01, 1'b0, 1'b0}) begin
                failed++;
                $display("FAIL parity_good: got %h need %h", got,
                         {8'h01, 1'b0, 1'b0});
            end
        end
        idle(BIT);
    endtask
`endif

    task automatic test_back_to_back();
        logic [DW-1:0] d;
        logic          sb, pb;
        logic [DW+1:0] exp, got;
        int            gap;
        for (int k = 0; k < 24; k++) begin
            d  = DW'($urandom);
            sb = ($urandom_range(0, 4) != 0);
            pb = (^d) ^ ($urandom_range(0, 3) == 0);
            exp = model(d, sb, pb);
            send_frame(d, sb, pb);
            wait_got(1, "b2b");
            if (got_q.size() > 0) begin
                got = got_q.pop_front();
                tests++;
                if (got !== exp) begin
                    failed++;
                    $display("FAIL b2b[%0d]: got %h need %h", k, got, exp);
                end
            end
            gap = sb ? $urandom_range(0, 2) : $urandom_range(1, 2);
            idle(gap * BIT);
        end
        idle(BIT);
        tests++;
        if (wide !== 0 || got_q.size() != 0) begin
            failed++;
            $display("FAIL b2b_pulses: wide=%0d extra=%0d need 0 0",
                     wide, got_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_glitch();
        test_frame_err();
        test_reset_mid();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL provide parameter DATA_BITS, default 8: number of data bits per frame.
REQ-002 SHALL provide parameter STOP_TICKS, default 16: oversample ticks spent in the stop state (16 = 1 stop bit).
REQ-003 SHALL provide port i_clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL provide port i_reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL provide port i_tick  input  1  one-cycle strobe at 16x baud, produced by the upstream baud tick generator.
REQ-006 SHALL provide port i_rx  input  1  serial line; idle high, asynchronous to i_clock.
REQ-007 SHALL provide port o_data  output  DATA_BITS  last received data word, LSB received first.
REQ-008 SHALL provide port o_rx_done  output  1  one-cycle pulse when a frame completes.
REQ-009 SHALL provide port o_frame_err  output  1  stop-bit sample was low; valid with o_rx_done.
REQ-010 SHALL provide port o_parity_err  output  1  parity mismatch; valid with o_rx_done.

Function
REQ-011 SHALL pass i_rx through a 2-flop synchronizer (both flops reset to 1); all line decisions SHALL use the synchronized value rx_s.
REQ-012 SHALL implement an FSM with states IDLE, START, DATA, PARITY, STOP; PARITY exists only per REQ-026.
REQ-013 SHALL maintain a 4-bit tick counter s_cnt and a bit counter n_cnt of width $clog2(DATA_BITS)+1; both advance only in cycles where i_tick=1.
REQ-014 IDLE: when rx_s=0, SHALL go to START with s_cnt=0, independent of i_tick.
REQ-015 START: on the tick at which s_cnt==7 (mid start bit), SHALL go to DATA with s_cnt=0 and n_cnt=0 if rx_s=0; otherwise SHALL return to IDLE with no output activity (glitch rejection).
REQ-016 DATA: on the tick at which s_cnt==15, SHALL shift rx_s into the MSB of the shift register (right shift), clear s_cnt and increment n_cnt; after the DATA_BITS-th sample SHALL go to PARITY if present, else STOP.
REQ-017 STOP: on the tick at which s_cnt==STOP_TICKS-1, SHALL sample rx_s, go to IDLE, and in that same edge load o_data, set o_frame_err=~rx_s, and assert o_rx_done.
REQ-018 o_rx_done SHALL be high for exactly one i_clock cycle per frame, including frames with errors; o_data and the error flags SHALL hold until the next o_rx_done.
REQ-019 Ticks arriving while in IDLE SHALL be ignored; clock cycles without a tick SHALL not change s_cnt, n_cnt or the shift register.
REQ-020 A new start bit SHALL be accepted in the first cycle after returning to IDLE (back-to-back frames with no idle gap).
REQ-021 SHALL use no latch or combinational path from i_rx to any output.

Reset
REQ-022 On i_reset=1, SHALL immediately force state=IDLE, s_cnt=0, n_cnt=0, shift register=0, o_data=0, o_rx_done=0, o_frame_err=0, o_parity_err=0.
REQ-023 Reset asserted mid-frame SHALL abandon the frame without an o_rx_done pulse; after release, the block SHALL wait in IDLE for a fresh falling edge.
REQ-024 Reset deassertion is synchronous to i_clock; the first rising edge after deassertion may advance the FSM.

Configuration
REQ-025 Macro UART_RX_PARITY_EN SHALL select parity support.
REQ-026 With UART_RX_PARITY_EN defined: after DATA, PARITY state SHALL sample rx_s on the tick at which s_cnt==15, then go to STOP; o_parity_err SHALL equal (XOR of data bits) XOR parity bit (even parity), updated with o_rx_done.
REQ-027 Without UART_RX_PARITY_EN: PARITY state and its logic SHALL be absent, DATA SHALL go directly to STOP, and o_parity_err SHALL be tied to 0.

Verification (i_tick every 4 clocks; 64 clocks per bit)
REQ-028 Reset, line idle high for 200 clocks -> o_rx_done stays 0, all outputs 0.
REQ-029 Frame 0xA3 with valid stop bit -> single o_rx_done pulse, o_data=0xA3, o_frame_err=0, o_parity_err=0 (parity build: parity bit 0).
REQ-030 Low glitch of 3 ticks (12 clocks) on an idle line -> FSM returns to IDLE, no o_rx_done.
REQ-031 Frame 0x55 with stop bit held low -> o_rx_done pulse, o_data=0x55, o_frame_err=1.
REQ-032 i_reset pulsed during data bit 4 of 0xFF, then frame 0x3C -> no pulse for 0xFF; next pulse carries o_data=0x3C.
REQ-033 Parity build: 0x01 sent with parity bit 0 -> o_parity_err=1; back-to-back 0x01 with parity bit 1 -> o_parity_err=0.
